// File: rtl/dest_reg_pipeline_tracker.sv
// Shifts the ID-stage destination register through EX/MEM/WB for hazard detection, inserting
// bubbles on stall/flush, and tracks stall behaviour with a watchdog FSM and a cycle counter.
module dest_reg_pipeline_tracker #(
  parameter int unsigned MAX_STALL = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_dest,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             pipeline_stall_n,
  output logic [2:0]       ex_op_dest,
  output logic [2:0]       mem_op_dest,
  output logic [2:0]       wb_op_dest,
  output logic             stall_active,
  output logic             hang,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned ConsecW = $clog2(MAX_STALL + 2);
  localparam logic [ConsecW-1:0] ConsecSat  = ConsecW'(MAX_STALL + 1);
  localparam logic [ConsecW-1:0] ConsecHang = ConsecW'(MAX_STALL);
  localparam logic [CNT_W-1:0]   CntOne     = {{(CNT_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StHung  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         ex_q, ex_d;
  logic [2:0]         mem_q, mem_d;
  logic [2:0]         wb_q, wb_d;
  logic [ConsecW-1:0] consec_q, consec_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               stall_active_q, stall_active_d;
  logic               hang_q, hang_d;
  logic               stall;

  // Anything other than a clean 1 (including X) counts as a stall.
  always_comb begin
    stall = 1'b1;
    if (pipeline_stall_n) begin
      stall = 1'b0;
    end
  end

  always_comb begin
    mem_d = ex_q;
    wb_d  = mem_q;
    ex_d  = 3'd0;
    if (!stall && !flush && id_valid) begin
      ex_d = id_dest;
    end
  end

  always_comb begin
    consec_d = 3'd0 == 3'd0 ? '0 : '0;
    if (stall) begin
      consec_d = (consec_q >= ConsecSat) ? ConsecSat : consec_q + 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (stall) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (!stall) begin
          state_d = StRun;
        end else if (consec_q >= ConsecHang) begin
          state_d = StHung;
        end
      end
      StHung:  state_d = StHung;
      default: state_d = StRun;
    endcase
    stall_active_d = (state_d == StStall);
    hang_d         = (state_d == StHung);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StRun;
      ex_q           <= 3'd0;
      mem_q          <= 3'd0;
      wb_q           <= 3'd0;
      consec_q       <= '0;
      stall_cnt_q    <= '0;
      stall_active_q <= 1'b0;
      hang_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      consec_q       <= consec_d;
      stall_cnt_q    <= stall_cnt_d;
      stall_active_q <= stall_active_d;
      hang_q         <= hang_d;
    end
  end

  assign ex_op_dest   = ex_q;
  assign mem_op_dest  = mem_q;
  assign wb_op_dest   = wb_q;
  assign stall_active = stall_active_q;
  assign hang         = hang_q;
  assign stall_cnt    = stall_cnt_q;

  stall_n_known_a: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(pipeline_stall_n));

endmodule

// File: tb/tb_dest_reg_pipeline_tracker.sv
// Self-checking bench: directed vector table, hand-written hang/reset sequences, then random
// stimulus against a queue-based reference model. A CNT_W=4 copy checks counter saturation.
module tb_dest_reg_pipeline_tracker;

  localparam int MaxStall = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_dest;
  logic        id_valid;
  logic        flush;
  logic        stall_n;
  logic [2:0]  ex, mem, wb;
  logic        sa, hg;
  logic [15:0] cnt;
  logic [2:0]  ex4, mem4, wb4;
  logic        sa4, hg4;
  logic [3:0]  cnt4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dest_reg_pipeline_tracker #(.MAX_STALL(MaxStall), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_dest(id_dest), .id_valid(id_valid), .flush(flush),
    .pipeline_stall_n(stall_n), .ex_op_dest(ex), .mem_op_dest(mem), .wb_op_dest(wb),
    .stall_active(sa), .hang(hg), .stall_cnt(cnt)
  );

  dest_reg_pipeline_tracker #(.MAX_STALL(MaxStall), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_dest(id_dest), .id_valid(id_valid), .flush(flush),
    .pipeline_stall_n(stall_n), .ex_op_dest(ex4), .mem_op_dest(mem4), .wb_op_dest(wb4),
    .stall_active(sa4), .hang(hg4), .stall_cnt(cnt4)
  );

  // Reference model: pipeline as a queue, watchdog as a stall run length.
  int m_pipe[$];
  int m_run;
  int m_cnt;
  bit m_hang;
  bit m_sa;

  function automatic void model_reset();
    m_pipe = '{0, 0, 0};
    m_run  = 0;
    m_cnt  = 0;
    m_hang = 0;
    m_sa   = 0;
  endfunction

  function automatic void model_edge(int dest, bit valid, bit fl, bit sn);
    int enter;
    enter = (!sn || fl || !valid) ? 0 : dest;
    m_pipe.push_front(enter);
    void'(m_pipe.pop_back());
    if (!sn) begin
      m_run++;
      m_cnt++;
    end else begin
      m_run = 0;
    end
    if (m_run > MaxStall) m_hang = 1;
    m_sa = !sn && !m_hang;
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(string name, int e_ex, int e_mem, int e_wb, bit e_sa, bit e_hg, int e_cnt);
    int e_cnt16, e_cnt4;
    e_cnt16 = sat(e_cnt, 65535);
    e_cnt4  = sat(e_cnt, 15);
    n_vec++;
    if (int'(ex) != e_ex || int'(mem) != e_mem || int'(wb) != e_wb || sa !== e_sa ||
        hg !== e_hg || int'(cnt) != e_cnt16 || int'(cnt4) != e_cnt4 || hg4 !== e_hg ||
        sa4 !== e_sa || int'(ex4) != e_ex) begin
      n_err++;
      $display("FAIL %s: got ex=%0d mem=%0d wb=%0d sa=%0b hang=%0b cnt=%0d cnt4=%0d ex4=%0d hang4=%0b, want ex=%0d mem=%0d wb=%0d sa=%0b hang=%0b cnt=%0d cnt4=%0d",
               name, ex, mem, wb, sa, hg, cnt, cnt4, ex4, hg4,
               e_ex, e_mem, e_wb, e_sa, e_hg, e_cnt16, e_cnt4);
    end
  endtask

  task automatic step(int dest, bit valid, bit fl, bit sn);
    id_dest  = 3'(dest);
    id_valid = valid;
    flush    = fl;
    stall_n  = sn;
    @(posedge clk);
    model_edge(dest, valid, fl, sn);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(string name);
    #1 rst = 1'b0;
    #1 check(name, 0, 0, 0, 0, 0, 0);
    model_reset();
    rst = 1'b1;
  endtask

  typedef struct {
    int dest; bit valid; bit fl; bit sn;
    int e_ex; int e_mem; int e_wb; bit e_sa; bit e_hg; int e_cnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{5, 1, 0, 1, 5, 0, 0, 0, 0, 0};
    tbl[1]  = '{5, 1, 0, 1, 5, 5, 0, 0, 0, 0};
    tbl[2]  = '{3, 1, 0, 1, 3, 5, 5, 0, 0, 0};
    tbl[3]  = '{4, 1, 0, 0, 0, 3, 5, 1, 0, 1};
    tbl[4]  = '{4, 1, 0, 0, 0, 0, 3, 1, 0, 2};
    tbl[5]  = '{4, 1, 0, 0, 0, 0, 0, 1, 0, 3};
    tbl[6]  = '{4, 1, 0, 1, 4, 0, 0, 0, 0, 3};
    tbl[7]  = '{6, 1, 1, 1, 0, 4, 0, 0, 0, 3};
    tbl[8]  = '{6, 1, 1, 0, 0, 0, 4, 1, 0, 4};
    tbl[9]  = '{7, 0, 0, 1, 0, 0, 0, 0, 0, 4};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 4};
    tbl[11] = '{2, 1, 0, 1, 2, 0, 0, 0, 0, 4};

    rst = 1'b0; id_dest = 3'd0; id_valid = 1'b0; flush = 1'b0; stall_n = 1'b1;
    model_reset();
    #2 check("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].dest, tbl[i].valid, tbl[i].fl, tbl[i].sn);
      check($sformatf("table_%0d", i), tbl[i].e_ex, tbl[i].e_mem, tbl[i].e_wb,
            tbl[i].e_sa, tbl[i].e_hg, tbl[i].e_cnt);
    end

    // Four consecutive stalls: watchdog fires on the fourth edge and stays set.
    step(1, 1, 0, 0); check("hang_s1", 0, 2, 0, 1, 0, 5);
    step(1, 1, 0, 0); check("hang_s2", 0, 0, 2, 1, 0, 6);
    step(1, 1, 0, 0); check("hang_s3", 0, 0, 0, 1, 0, 7);
    step(1, 1, 0, 0); check("hang_s4", 0, 0, 0, 0, 1, 8);
    step(1, 1, 0, 1); check("hang_sticky1", 1, 0, 0, 0, 1, 8);
    step(6, 1, 0, 1); check("hang_sticky2", 6, 1, 0, 0, 1, 8);
    step(5, 1, 0, 0); check("hang_bubble", 0, 6, 1, 0, 1, 9);
    async_reset("reset_in_hung");

    // Stall run cut at three restarts the watchdog count.
    step(3, 1, 0, 0); step(3, 1, 0, 0); step(3, 1, 0, 0);
    step(3, 1, 0, 1); check("run3_ok", 3, 0, 0, 0, 0, 3);
    step(3, 1, 0, 0); step(3, 1, 0, 0); step(3, 1, 0, 0);
    check("run3_again", 0, 0, 0, 1, 0, 6);
    async_reset("reset_mid_stall");

    // Alternating stalls saturate the narrow counter.
    for (int i = 0; i < 40; i++) step(i % 8, 1, 0, (i % 2) == 1);
    check("sat_alternate", m_pipe[0], m_pipe[1], m_pipe[2], 0, 0, 20);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1);
      check("random", m_pipe[0], m_pipe[1], m_pipe[2], m_sa, m_hang, m_cnt);
      if ($urandom_range(0, 99) == 0) async_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dest_reg_pipeline_tracker.md
Name: dest_reg_pipeline_tracker

Overview:
- Sequential producer of the destination-register fields that `hazard_detection_unit` consumes: `ex_op_dest`, `mem_op_dest` and `wb_op_dest`.
- Consumes that unit's `pipeline_stall_n`, closing the loop.
- Shifts the ID-stage destination through EX/MEM/WB, inserts a bubble on stall or flush, and tracks stall behaviour (FSM, consecutive-stall watchdog, saturating stall-cycle performance counter).
- Sits in the MIPS16 pipeline control path beside the ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- MAX_STALL, 3: consecutive stall cycles allowed. Exceeding this (a count of MAX_STALL+1) is a hang.
- CNT_W, 16: width of the total stall-cycle performance counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- id_dest  input  3  destination register of the instruction in ID. 0 means no write.
- id_valid  input  1  ID holds a real instruction.
- flush  input  1  kill the ID instruction (taken branch/jump).
- pipeline_stall_n  input  1  from hazard_detection_unit. 0 = stall this cycle.
- ex_op_dest  output  3  destination in EX (0 = none).
- mem_op_dest  output  3  destination in MEM.
- wb_op_dest  output  3  destination in WB.
- stall_active  output  1  FSM in STALL.
- hang  output  1  FSM in HUNG (sticky).
- stall_cnt  output  CNT_W  total stall cycles, saturating.

Behaviour:
- Reset (rst=0, asynchronous):
  - ex/mem/wb_op_dest = 0, stall_cnt = 0, consecutive counter = 0.
  - FSM = RUN, so stall_active = 0 and hang = 0.
  - Release is sampled on the first rising clk edge with rst=1.
- Register 0 is never a hazard source. A dest of 0 is the bubble encoding.
- Per rising edge, with all stages updating simultaneously:
  - mem_op_dest <= ex_op_dest
  - wb_op_dest <= mem_op_dest
  - ex_op_dest <= 0 if (pipeline_stall_n==0 || flush || !id_valid), else id_dest.
- Latency: a valid, unstalled id_dest appears on ex_op_dest 1 cycle later, mem 2 cycles later, wb 3 cycles later.
- During a stall, older stages keep draining and a bubble enters EX. The ID instruction is held upstream and re-presented the next cycle.
- Stall and flush in the same cycle insert a single bubble, which is identical to either event alone.
- Consecutive-stall counter `consec` (internal, width clog2(MAX_STALL+2)):
  - Increments on each stall cycle.
  - Clears on any cycle with pipeline_stall_n=1.
  - Saturates at MAX_STALL+1.
- FSM:
  - RUN → STALL when pipeline_stall_n=0.
  - STALL → RUN when pipeline_stall_n=1.
  - STALL → HUNG when pipeline_stall_n=0 and consec==MAX_STALL, i.e. on the (MAX_STALL+1)-th consecutive stall cycle.
  - HUNG is absorbing. Only reset leaves it.
  - While in HUNG, bubble insertion still follows pipeline_stall_n.
- Outputs from the FSM:
  - stall_active = (state==STALL), registered.
  - hang = (state==HUNG), registered.
  - Both assert the edge after the triggering condition.
- stall_cnt:
  - +1 on every edge where pipeline_stall_n=0, in any state.
  - Saturates at 2^CNT_W-1 with no wrap.
- X on pipeline_stall_n is treated as stall; a verification assertion flags it.
- Reset mid-stall or in HUNG clears all state immediately, without waiting for clk.

Test Plan:
- Reset, then id_valid=1, id_dest=5, stall_n=1 every cycle → ex=5 at cycle 1, mem=5 at cycle 2, wb=5 at cycle 3. stall_cnt=0.
- Issue id_dest=3, then a dependent instruction reading r3, with the hazard unit closed-loop → stall_n low for 3 cycles. Bubbles give ex=0. stall_active high for 3 cycles then low. stall_cnt=3. hang=0.
- Force stall_n=0 for 4 consecutive cycles → hang=1 after the 4th edge and stays 1 with stall_n=1. A subsequent rst=0 pulse asserted between clk edges → all outputs 0 immediately.
- flush=1 with id_valid=1, id_dest=6 → ex=0 next cycle. Simultaneous flush and stall → exactly one bubble. stall_cnt increments by 1.
- CNT_W=4, alternate stall_n 0/1 for 40 cycles → stall_cnt saturates at 15, no wrap. hang stays 0.
- id_valid=0 with id_dest=7, or id_dest=0 → ex=0. No stall is produced by the hazard unit for an r0 source.
